// File: rtl/rf_pkg.sv
// rf_pkg: shared widths, requester indices and pointer-width helper for the writeback scheduler.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package rf_pkg;
  localparam int AW_DEF   = 5;
  localparam int DW_DEF   = 32;
  localparam int NREQ_DEF = 3;
  localparam int NREG_DEF = 2**AW_DEF;

  // Writeback requester indices
  localparam int SRC_ALU  = 0;
  localparam int SRC_LOAD = 1;
  localparam int SRC_MDU  = 2;

  // Width of the arbitration pointer; never narrower than one bit
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rf_wb_arb.sv
// rf_wb_arb: one-hot grant among valid writeback requesters, search starting at ptr+1 mod NREQ.
// Latency: purely combinational.
// Backpressure: none; grants whenever any request is valid (a pointer of NREQ-1 gives lowest-index priority).
module rf_wb_arb
  import rf_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int PW   = ptr_width(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant
);

  logic [PW-1:0] idx;
  logic          found;

  // Walk the requesters once, starting just after the pointer, and grant the first valid one
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = PW'((int'(ptr) + k) % NREQ);
      if (!found && req_valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_wb_sched.sv
// rf_wb_sched: register busy scoreboard plus single-port writeback arbitration; RF_WB_RR_EN selects round-robin.
// Latency: stall/req_ready combinational; rf_w/waddr/wdata registered one cycle after the transfer.
// Backpressure: write port drains every cycle, so one valid requester is always granted (none during rst).
module rf_wb_sched
  import rf_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic [AW-1:0]     issue_waddr,
  input  logic [AW-1:0]     raddr1,
  input  logic [AW-1:0]     raddr2,
  output logic              stall,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*AW-1:0] req_waddr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]   req_ready,
  output logic              rf_w,
  output logic [AW-1:0]     waddr,
  output logic [DW-1:0]     wdata
);

  localparam int            NREG    = 2**AW;
  localparam int            PW      = ptr_width(NREQ);
  localparam logic [PW-1:0] PTR_RST = PW'(NREQ-1);

  logic [NREG-1:0] busy_q, busy_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic            rf_w_q, rf_w_d;
  logic [AW-1:0]   waddr_q, waddr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [NREQ-1:0] grant;
  logic            xfer;
  logic            issue_go;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;
`ifdef RF_WB_RR_EN
  logic [PW-1:0]   sel_idx;
`endif

  // Held at PTR_RST in fixed-priority builds, which makes the search start at index 0
  rf_wb_arb #(.NREQ(NREQ), .PW(PW)) u_arb (
    .req_valid (req_valid),
    .ptr       (ptr_q),
    .grant     (grant)
  );

  assign req_ready = rst ? '0 : grant;
  assign stall     = busy_q[raddr1] | busy_q[raddr2] | (issue_valid & busy_q[issue_waddr]);
  assign issue_go  = issue_valid & ~stall & (issue_waddr != '0);

  // Pick the address/data slice of the requester that transfers this cycle
  always_comb begin
    xfer     = 1'b0;
    sel_addr = '0;
    sel_data = '0;
`ifdef RF_WB_RR_EN
    sel_idx  = '0;
`endif
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        xfer     = 1'b1;
        sel_addr = req_waddr[i*AW +: AW];
        sel_data = req_wdata[i*DW +: DW];
`ifdef RF_WB_RR_EN
        sel_idx  = PW'(i);
`endif
      end
    end
  end

  // Next state: writeback clears busy first, then an accepted issue sets it so set wins on a collision
  always_comb begin
    busy_d  = busy_q;
    rf_w_d  = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    ptr_d   = ptr_q;
    if (xfer) begin
      rf_w_d            = (sel_addr != '0);
      waddr_d           = sel_addr;
      wdata_d           = sel_data;
      busy_d[sel_addr]  = 1'b0;
`ifdef RF_WB_RR_EN
      ptr_d             = sel_idx;
`endif
    end
    if (issue_go) begin
      busy_d[issue_waddr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // State registers with synchronous reset; reset also drops any pending writeback
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= '0;
      ptr_q   <= PTR_RST;
      rf_w_q  <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      busy_q  <= busy_d;
      ptr_q   <= ptr_d;
      rf_w_q  <= rf_w_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign rf_w  = rf_w_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;

endmodule

// File: tb/tb_rf_wb_sched.sv
// tb_rf_wb_sched: directed vector table, arbitration/reset sequences and randomized run against a scoreboard model.
// Latency: checks combinational outputs 1ns after inputs change, registered outputs 1ns after the rising edge.
// Backpressure: n/a.
module tb_rf_wb_sched;
  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;

  typedef struct {
    logic        rst;
    logic        iv;
    logic [4:0]  iw;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [2:0]  rv;
    logic [4:0]  a [3];
    logic [31:0] d [3];
    logic        stall;
    logic [2:0]  rdy;
    logic        rfw;
    logic [4:0]  wa;
    logic [31:0] wd;
  } vec_t;

  logic              clk;
  logic              rst;
  logic              issue_valid;
  logic [AW-1:0]     issue_waddr, raddr1, raddr2;
  logic              stall;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*AW-1:0] req_waddr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]   req_ready;
  logic              rf_w;
  logic [AW-1:0]     waddr;
  logic [DW-1:0]     wdata;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: busy set of registers, arbitration pointer, last write-port contents
  bit          m_busy [32];
  int          m_ptr;
  logic        m_rfw;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;

  vec_t tbl [17];
  vec_t seq [3];

  rf_wb_sched #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_waddr (issue_waddr),
    .raddr1      (raddr1),
    .raddr2      (raddr2),
    .stall       (stall),
    .req_valid   (req_valid),
    .req_waddr   (req_waddr),
    .req_wdata   (req_wdata),
    .req_ready   (req_ready),
    .rf_w        (rf_w),
    .waddr       (waddr),
    .wdata       (wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(int rst_v, int iv, int iw, int r1, int r2, int rv,
                              int a0, int d0, int a1, int d1, int a2, int d2,
                              int st, int rdy, int rfw, int wa, int wd);
    vec_t v;
    v.rst = 1'(rst_v); v.iv = 1'(iv); v.iw = 5'(iw); v.r1 = 5'(r1); v.r2 = 5'(r2);
    v.rv = 3'(rv);
    v.a[0] = 5'(a0); v.a[1] = 5'(a1); v.a[2] = 5'(a2);
    v.d[0] = 32'(d0); v.d[1] = 32'(d1); v.d[2] = 32'(d2);
    v.stall = 1'(st); v.rdy = 3'(rdy); v.rfw = 1'(rfw); v.wa = 5'(wa); v.wd = 32'(wd);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  // Grant choice straight from the arbitration rule
  function automatic int model_pick(input logic [2:0] rv);
`ifdef RF_WB_RR_EN
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (m_ptr + k) % NREQ;
      if (rv[idx]) return idx;
    end
`else
    for (int i = 0; i < NREQ; i++) begin
      if (rv[i]) return i;
    end
`endif
    return -1;
  endfunction

  // One clock cycle: mode 0 = no checks, 1 = compare to vector, 2 = compare to model
  task automatic step(input vec_t v, input int mode);
    logic       e_stall;
    logic [2:0] e_rdy;
    int         g;
    @(negedge clk);
    rst         = v.rst;
    issue_valid = v.iv;
    issue_waddr = v.iw;
    raddr1      = v.r1;
    raddr2      = v.r2;
    req_valid   = v.rv;
    req_waddr   = {v.a[2], v.a[1], v.a[0]};
    req_wdata   = {v.d[2], v.d[1], v.d[0]};
    #1;
    e_stall = m_busy[v.r1] || m_busy[v.r2] || (v.iv && m_busy[v.iw]);
    g = v.rst ? -1 : model_pick(v.rv);
    e_rdy = (g >= 0) ? 3'(1 << g) : 3'b000;
    if (mode == 1) begin
      chk("stall", 32'(stall), 32'(v.stall));
      chk("req_ready", 32'(req_ready), 32'(v.rdy));
    end else if (mode == 2) begin
      chk("stall_model", 32'(stall), 32'(e_stall));
      chk("req_ready_model", 32'(req_ready), 32'(e_rdy));
    end
    @(posedge clk);
    if (v.rst) begin
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_rfw = 1'b0; m_wa = '0; m_wd = '0; m_ptr = NREQ - 1;
    end else begin
      m_rfw = 1'b0;
      if (g >= 0) begin
        m_rfw = (v.a[g] != 0);
        m_wa  = v.a[g];
        m_wd  = v.d[g];
        if (v.a[g] != 0) m_busy[v.a[g]] = 1'b0;
`ifdef RF_WB_RR_EN
        m_ptr = g;
`endif
      end
      if (v.iv && !e_stall && v.iw != 0) m_busy[v.iw] = 1'b1;
    end
    #1;
    if (mode == 1) begin
      chk("rf_w", 32'(rf_w), 32'(v.rfw));
      chk("waddr", 32'(waddr), 32'(v.wa));
      chk("wdata", wdata, v.wd);
    end else if (mode == 2) begin
      chk("rf_w_model", 32'(rf_w), 32'(m_rfw));
      chk("waddr_model", 32'(waddr), 32'(m_wa));
      chk("wdata_model", wdata, m_wd);
    end
  endtask

  initial begin
    vec_t rv_v;
    rst = 1'b1; issue_valid = 1'b0; issue_waddr = '0; raddr1 = '0; raddr2 = '0;
    req_valid = '0; req_waddr = '0; req_wdata = '0;
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_ptr = NREQ - 1; m_rfw = 1'b0; m_wa = '0; m_wd = '0;

    //              rst iv iw r1 r2 rv  a0 d0            a1 d1            a2 d2          st rdy rfw wa wd
    tbl[0]  = mk(1, 0, 0, 0, 0, 0,  0, 0,            0, 0,            0, 0,          0, 0, 0, 0,  0);
    tbl[1]  = mk(0, 1, 5, 1, 2, 0,  0, 0,            0, 0,            0, 0,          0, 0, 0, 0,  0);
    tbl[2]  = mk(0, 0, 0, 5, 0, 1,  5, 'h1234,       0, 0,            0, 0,          1, 1, 1, 5,  'h1234);
    tbl[3]  = mk(0, 0, 0, 5, 0, 0,  0, 0,            0, 0,            0, 0,          0, 0, 0, 5,  'h1234);
    tbl[4]  = mk(0, 1, 7, 0, 0, 0,  0, 0,            0, 0,            0, 0,          0, 0, 0, 5,  'h1234);
    tbl[5]  = mk(0, 0, 0, 7, 0, 0,  0, 0,            0, 0,            0, 0,          1, 0, 0, 5,  'h1234);
    tbl[6]  = mk(0, 0, 0, 7, 0, 2,  0, 0,            7, 'hAAAA5555,   0, 0,          1, 2, 1, 7,  'hAAAA5555);
    tbl[7]  = mk(0, 0, 0, 7, 0, 0,  0, 0,            0, 0,            0, 0,          0, 0, 0, 7,  'hAAAA5555);
    tbl[8]  = mk(0, 1, 9, 0, 0, 2,  0, 0,            9, 'h99,         0, 0,          0, 2, 1, 9,  'h99);
    tbl[9]  = mk(0, 0, 0, 0, 9, 0,  0, 0,            0, 0,            0, 0,          1, 0, 0, 9,  'h99);
    tbl[10] = mk(0, 0, 0, 0, 9, 4,  0, 0,            0, 0,            9, 'h9999,     1, 4, 1, 9,  'h9999);
    tbl[11] = mk(0, 0, 0, 0, 9, 0,  0, 0,            0, 0,            0, 0,          0, 0, 0, 9,  'h9999);
    tbl[12] = mk(0, 0, 0, 0, 0, 1,  0, 'hFFFFFFFF,   0, 0,            0, 0,          0, 1, 0, 0,  'hFFFFFFFF);
    tbl[13] = mk(0, 1, 0, 0, 0, 0,  0, 0,            0, 0,            0, 0,          0, 0, 0, 0,  'hFFFFFFFF);
    tbl[14] = mk(0, 1, 3, 0, 0, 0,  0, 0,            0, 0,            0, 0,          0, 0, 0, 0,  'hFFFFFFFF);
    tbl[15] = mk(0, 0, 0, 3, 0, 1,  12, 'h55,        0, 0,            0, 0,          1, 1, 1, 12, 'h55);
    tbl[16] = mk(1, 0, 0, 3, 0, 7,  1, 1,            2, 2,            3, 3,          1, 0, 0, 0,  0);

`ifdef RF_WB_RR_EN
    seq[0] = mk(0, 0, 0, 0, 0, 7,  20, 'h100, 21, 'h101, 22, 'h102,  0, 1, 1, 20, 'h100);
    seq[1] = mk(0, 0, 0, 0, 0, 7,  20, 'h100, 21, 'h101, 22, 'h102,  0, 2, 1, 21, 'h101);
    seq[2] = mk(0, 0, 0, 0, 0, 7,  20, 'h100, 21, 'h101, 22, 'h102,  0, 4, 1, 22, 'h102);
`else
    seq[0] = mk(0, 0, 0, 0, 0, 7,  20, 'h100, 21, 'h101, 22, 'h102,  0, 1, 1, 20, 'h100);
    seq[1] = mk(0, 0, 0, 0, 0, 7,  20, 'h100, 21, 'h101, 22, 'h102,  0, 1, 1, 20, 'h100);
    seq[2] = mk(0, 0, 0, 0, 0, 7,  20, 'h100, 21, 'h101, 22, 'h102,  0, 1, 1, 20, 'h100);
`endif

    // Initial reset, unchecked
    step(tbl[0], 0);
    step(tbl[0], 0);

    // Directed vectors
    for (int i = 0; i < 17; i++) step(tbl[i], 1);

    // Cycle after reset: nothing may look busy, no pending write
    @(negedge clk);
    rst = 1'b0; issue_valid = 1'b0; req_valid = '0;
    #1;
    chk("rf_w_after_rst", 32'(rf_w), 32'(0));
    for (int a = 0; a < 32; a++) begin
      raddr1 = 5'(a); raddr2 = 5'(a);
      #1;
      chk("stall_after_rst", 32'(stall), 32'(0));
    end

    // All three requesters valid for three cycles
    for (int i = 0; i < 3; i++) step(seq[i], 1);

    // Randomized run against the model
    rv_v = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(rv_v, 2);
    for (int n = 0; n < 400; n++) begin
      rv_v.rst = ($urandom_range(0, 49) == 0);
      rv_v.iv  = 1'($urandom_range(0, 1));
      rv_v.iw  = 5'($urandom_range(0, 7));
      rv_v.r1  = 5'($urandom_range(0, 7));
      rv_v.r2  = 5'($urandom_range(0, 7));
      rv_v.rv  = 3'($urandom_range(0, 7));
      for (int k = 0; k < 3; k++) begin
        rv_v.a[k] = 5'($urandom_range(0, 7));
        rv_v.d[k] = $urandom;
      end
      step(rv_v, 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
